reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Writer side of the register file's single write port.
- Merges two result sources into one registered write per cycle: single-cycle ALU results and multi-cycle load results arriving over a valid/ready handshake.
- Load results that cannot be written immediately wait in a small in-order FIFO; a starvation counter guarantees the FIFO drains.
- Sits between the execute/memory stages and the register file; decode uses its query ports to see values not yet written.

Parameters:
- DEPTH, 4, load-result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4, consecutive ALU-won cycles with FIFO non-empty before the FIFO is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU result not accepted this cycle; upstream holds it
- mem_valid  in  1  load result offered
- mem_ready  out  1  FIFO can accept a load result
- mem_addr  in  5  load destination register
- mem_data  in  32  load result
- should_write  out  1  register-file write enable (registered)
- write_addr  out  5  register-file write address (registered)
- write_data  out  32  register-file write data (registered)
- busy  out  1  FIFO non-empty
- query_addr1, query_addr2  in  5 each  decode source addresses
- query_hit1, query_hit2  out  1 each  pending newer value exists
- query_data1, query_data2  out  32 each  that pending value

Behaviour:
- Interface: single clock clk; reset is synchronous, active-high, and sampled on the rising edge of clk.
- Reset values: should_write=0, write_addr=0, write_data=0, FIFO empty, starve count=0. While reset is high, mem_ready=0 and alu_stall=0.
- Reset mid-operation discards all queued entries and any pending write. No write reaches the register file on the edge where reset is sampled high.
- mem_ready is combinational: !reset && count<DEPTH. There is no push-while-full look-ahead: when full, mem_ready=0 even if a pop happens the same cycle.
- Load handshake: an entry is accepted on an edge where mem_valid && mem_ready. If mem_addr==0, the handshake completes but nothing is enqueued.
- ALU results with alu_addr==0 are accepted and dropped. They never count as winning the port.
- Arbitration (per cycle, decided combinationally, registered at the edge):
  1. force = (starve==STARVE_LIMIT) && busy.
  2. If force: pop the FIFO head to the output and set alu_stall = alu_valid && alu_addr!=0.
  3. Else if alu_valid && alu_addr!=0: ALU drives the output and alu_stall=0.
  4. Else if busy: pop the FIFO head.
  5. Else: should_write=0 next cycle.
- Starve counter:
  - Increments on each edge where the ALU wins while busy.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Latency:
  - ALU result: visible on write_* one cycle after acceptance.
  - Load result into an empty FIFO with no ALU traffic: enqueued at edge N, write_* asserted after edge N+1. The enqueue and pop of the same entry in one cycle is not allowed.
- Simultaneous push and pop on a non-full FIFO: count is unchanged. Pointers wrap modulo DEPTH.
- Ordering between sources is not enforced by this block. Issue logic uses busy/query_hit to stall same-destination hazards.
- The register file samples reads before writes, so the registered write_* value is treated as still pending by the bypass.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - query_hitN=1 when query_addrN!=0 and it matches a valid FIFO entry or (should_write && write_addr).
  - Youngest match wins: FIFO tail-most entry first, then the output register.
  - query_dataN carries the matching data.
  - Purely combinational from registered state.
- Undefined: query_hitN=0 and query_dataN=0. The ports remain present.

Decomposition:
- Package wb_pkg holds:
  - XLEN=32, REG_ADDR_W=5, ZERO_REG=0.
  - Struct wb_entry_t {addr, data}.
- Sub-module wb_fifo: synchronous DEPTH-entry FIFO of wb_entry_t.
  - Provides push/pop, full/empty/count, and a flattened entry+valid view for the bypass search.

Test Plan:
- Reset held 2 cycles, then idle → should_write=0, mem_ready=1, busy=0, all query_hit=0.
- ALU write x1=0x11 one cycle; then load x2=0x22 with no ALU traffic → write_* shows x1/0x11 one cycle after; x2/0x22 appears 2 cycles after the load handshake.
- alu_addr=0 and mem_addr=0 writes with data 0xFFFFFFFF → handshakes complete, should_write never asserts, busy stays 0.
- DEPTH+1 back-to-back loads while ALU writes every cycle → mem_ready drops after 4 accepted; after 4 ALU wins the FIFO pops once with alu_stall=1 that cycle; all loads later written in order.
- WB_BYPASS_EN, x5 queued twice (0xA then 0xB), query_addr1=5 → hit1=1, data1=0xB. Same test without the macro → hit1=0.
- Reset asserted with 3 queued entries → next cycle busy=0 and should_write=0; the dropped entries are never written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(0);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order load-result FIFO; also exposes its live entries oldest-first for bypass search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output wb_entry_t [DEPTH-1:0]        entries,
    output logic [DEPTH-1:0]             valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Slot i holds the i-th oldest entry, so higher valid indices are younger.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr + PTR_W'(i)];
            valid[i]   = (CNT_W'(i) < cnt);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Single register-file write port arbitrating ALU results against queued load results.
// Optional macro WB_BYPASS_EN enables the pending-value query ports.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [REG_ADDR_W-1:0]  alu_addr,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   alu_stall,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_ADDR_W-1:0]  mem_addr,
    input  logic [XLEN-1:0]        mem_data,
    output logic                   should_write,
    output logic [REG_ADDR_W-1:0]  write_addr,
    output logic [XLEN-1:0]        write_data,
    output logic                   busy,
    input  logic [REG_ADDR_W-1:0]  query_addr1,
    input  logic [REG_ADDR_W-1:0]  query_addr2,
    output logic                   query_hit1,
    output logic                   query_hit2,
    output logic [XLEN-1:0]        query_data1,
    output logic [XLEN-1:0]        query_data2
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0]   starve;
    wb_entry_t             head;
    wb_entry_t             push_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic                  alu_live;
    logic                  alu_win;
    logic                  fifo_force;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .entries    (entries),
        .valid      (valid)
    );

    // Port arbitration; the FIFO only pops entries that were already stored.
    always_comb begin
        busy       = (count != '0);
        alu_live   = alu_valid && (alu_addr != ZERO_REG);
        fifo_force = (starve == STARVE_W'(STARVE_LIMIT)) && busy;
        pop        = busy && (fifo_force || !alu_live);
        alu_win    = alu_live && !fifo_force;
        alu_stall  = !reset && fifo_force && alu_live;
        mem_ready  = !reset && !full;
        push       = mem_valid && mem_ready && (mem_addr != ZERO_REG);
        push_entry = '{addr: mem_addr, data: mem_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve <= '0;
        end else if (pop || empty) begin
            starve <= '0;
        end else if (alu_win && (starve != STARVE_W'(STARVE_LIMIT))) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            should_write <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else if (pop) begin
            should_write <= 1'b1;
            write_addr   <= head.addr;
            write_data   <= head.data;
        end else if (alu_win) begin
            should_write <= 1'b1;
            write_addr   <= alu_addr;
            write_data   <= alu_data;
        end else begin
            should_write <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Youngest pending value wins: FIFO tail beats head, FIFO beats the output register.
    function automatic logic [XLEN:0] lookup(
        input logic [REG_ADDR_W-1:0] qa,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]      vld,
        input logic                  sw,
        input logic [REG_ADDR_W-1:0] wa,
        input logic [XLEN-1:0]       wd
    );
        logic [XLEN:0] r;
        r = '0;
        if (qa != ZERO_REG) begin
            if (sw && (wa == qa)) r = {1'b1, wd};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld[i] && (ents[i].addr == qa)) r = {1'b1, ents[i].data};
            end
        end
        return r;
    endfunction

    always_comb begin
        {query_hit1, query_data1} = lookup(query_addr1, entries, valid,
                                           should_write, write_addr, write_data);
        {query_hit2, query_data2} = lookup(query_addr2, entries, valid,
                                           should_write, write_addr, write_data);
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{entries, valid, query_addr1, query_addr2};

    always_comb begin
        query_hit1  = 1'b0;
        query_hit2  = 1'b0;
        query_data1 = '0;
        query_data2 = '0;
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed cases plus random traffic against a queue model.
module tb_reg_writeback;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        should_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        busy;
    logic [4:0]  query_addr1;
    logic [4:0]  query_addr2;
    logic        query_hit1;
    logic        query_hit2;
    logic [31:0] query_data1;
    logic [31:0] query_data2;

    reg_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_stall    (alu_stall),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .should_write (should_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy         (busy),
        .query_addr1  (query_addr1),
        .query_addr2  (query_addr2),
        .query_hit1   (query_hit1),
        .query_hit2   (query_hit2),
        .query_data1  (query_data1),
        .query_data2  (query_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending loads as a queue, plus the expected write register.
    wb_entry_t   q[$];
    int          starve   = 0;
    bit          m_sw     = 0;
    logic [4:0]  m_wa     = 0;
    logic [31:0] m_wd     = 0;
    bit          m_zeroed = 0;
    bit          checking = 0;

    initial begin
        int        sz;
        bit        live;
        bit        frc;
        bit        accept;
        wb_entry_t e;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                starve   = 0;
                m_sw     = 0;
                m_wa     = 0;
                m_wd     = 0;
                m_zeroed = 1;
                checking = 1;
            end else begin
                m_zeroed = 0;
                sz     = q.size();
                live   = alu_valid && (alu_addr != 5'd0);
                frc    = (starve == LIMIT) && (sz > 0);
                accept = mem_valid && (sz < DEPTH) && (mem_addr != 5'd0);
                if (sz > 0 && (frc || !live)) begin
                    m_sw = 1;
                    m_wa = q[0].addr;
                    m_wd = q[0].data;
                    void'(q.pop_front());
                    starve = 0;
                end else if (live) begin
                    m_sw = 1;
                    m_wa = alu_addr;
                    m_wd = alu_data;
                    starve = (sz == 0) ? 0 : ((starve < LIMIT) ? starve + 1 : starve);
                end else begin
                    m_sw   = 0;
                    starve = 0;
                end
                if (accept) begin
                    e.addr = mem_addr;
                    e.data = mem_data;
                    q.push_back(e);
                end
            end
        end
    end

    function automatic logic [32:0] ref_query(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr == a) return {1'b1, q[i].data};
        if (m_sw && m_wa == a) return {1'b1, m_wd};
`endif
        return '0;
    endfunction

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [32:0] r1;
        logic [32:0] r2;
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("should_write", should_write, m_sw);
                if (m_sw || m_zeroed) begin
                    chk("write_addr", write_addr, m_wa);
                    chk("write_data", write_data, m_wd);
                end
                chk("busy", busy, q.size() > 0);
                chk("mem_ready", mem_ready, !reset && q.size() < DEPTH);
                chk("alu_stall", alu_stall,
                    !reset && starve == LIMIT && q.size() > 0 && alu_valid && alu_addr != 5'd0);
                r1 = ref_query(query_addr1);
                r2 = ref_query(query_addr2);
                chk("query_hit1", query_hit1, r1[32]);
                chk("query_hit2", query_hit2, r2[32]);
                if (r1[32] || !BYP) chk("query_data1", query_data1, r1[31:0]);
                if (r2[32] || !BYP) chk("query_data2", query_data2, r2[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
    endtask

    initial begin
        int          acc;
        int          k;
        int          first_block;
        int          first_stall;
        int          sw_seen;
        bit          hs;
        bit          stalled;
        logic [4:0]  seen[$];

        idle_inputs();
        query_addr1 = 0; query_addr2 = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        query_addr1 = 1;
        tick();
        chk("idle_sw", should_write, 0);
        chk("idle_ready", mem_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_hit1", query_hit1, 0);

        // ALU write then a load into an empty FIFO
        alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
        tick();
        alu_valid = 0; mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
        chk("alu_sw", should_write, 1);
        chk("alu_addr", write_addr, 1);
        chk("alu_data", write_data, 32'h11);
        tick();
        mem_valid = 0;
        chk("load_n_sw", should_write, 0);
        chk("load_n_busy", busy, 1);
        tick();
        chk("load_sw", should_write, 1);
        chk("load_addr", write_addr, 2);
        chk("load_data", write_data, 32'h22);
        chk("load_busy", busy, 0);

        // Writes to x0 complete but are dropped
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFF_FFFF;
        mem_valid = 1; mem_addr = 0; mem_data = 32'hFFFF_FFFF;
        chk("x0_ready", mem_ready, 1);
        tick();
        idle_inputs();
        chk("x0_sw", should_write, 0);
        chk("x0_busy", busy, 0);
        tick();
        chk("x0_sw2", should_write, 0);

        // DEPTH+1 loads against continuous ALU traffic
        acc = 0; k = 0; first_block = -1; first_stall = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            alu_valid = (acc < DEPTH + 1);
            alu_addr  = 5'(10 + (k % 5));
            alu_data  = 32'(k);
            mem_valid = (acc < DEPTH + 1);
            mem_addr  = 5'(20 + acc);
            mem_data  = 32'h100 + 32'(acc);
            #1;
            if (mem_valid && !mem_ready && first_block < 0) first_block = cyc;
            if (alu_stall && first_stall < 0) first_stall = cyc;
            hs      = mem_valid && mem_ready;
            stalled = alu_stall;
            tick();
            if (hs) acc++;
            if (!stalled) k++;
            if (should_write && write_addr >= 20 && write_addr <= 24) seen.push_back(write_addr);
        end
        idle_inputs();
        chk("first_block", 32'(first_block), 4);
        chk("first_stall", 32'(first_stall), 5);
        chk("loads_written", 32'(seen.size()), 5);
        for (int i = 0; i < 5; i++)
            chk("load_order", (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(20 + i));

        // x5 queued twice behind ALU traffic
        query_addr1 = 5;
        alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
        mem_valid = 1; mem_addr = 5; mem_data = 32'hA;
        tick();
        mem_data = 32'hB;
        tick();
        mem_valid = 0;
        chk("byp_hit1", query_hit1, BYP);
        chk("byp_data1", query_data1, BYP ? 32'hB : 32'h0);

        // Reset drops queued entries
        mem_valid = 1; mem_addr = 6; mem_data = 32'hC;
        tick();
        chk("pre_rst_busy", busy, 1);
        idle_inputs();
        reset = 1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_sw", should_write, 0);
        reset = 0;
        sw_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (should_write) sw_seen++;
        end
        chk("rst_dropped", 32'(sw_seen), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            alu_valid   = $urandom_range(0, 1);
            alu_addr    = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            mem_valid   = ($urandom_range(0, 9) < 6);
            mem_addr    = 5'($urandom_range(0, 7));
            mem_data    = $urandom;
            query_addr1 = 5'($urandom_range(0, 7));
            query_addr2 = 5'($urandom_range(0, 7));
            tick();
        end
        reset = 0;
        idle_inputs();
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
